// File: rtl/mips32_fetch_unit.sv
// rtl/mips32_fetch_unit.sv - decoupled MIPS32 fetch: registered PC, req/ack imem port, instruction FIFO, redirect and precise fetch fault
module mips32_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h00400000,
  parameter int unsigned TEXT_BYTES   = 4096,
  parameter int unsigned IMEM_AW      = 10,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc,
  output logic               fault_valid,
  output logic [31:0]        fault_pc
);

  localparam int unsigned PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] TEXT_SIZE = 32'(TEXT_BYTES);
  localparam logic [PW:0] DEPTH_C   = (PW+1)'(FIFO_DEPTH);

  logic [31:0]        r_pc;
  logic [31:0]        r_fault_pc;
  logic               r_req;
  logic               r_drop;
  logic               r_fault;
  logic [IMEM_AW-1:0] r_addr;
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [PW:0]        r_count;
  logic [31:0]        r_fifo_inst [FIFO_DEPTH];
  logic [31:0]        r_fifo_pc   [FIFO_DEPTH];

  logic [31:0] w_off;
  logic        w_pc_ok;
  logic        w_ack;
  logic        w_push;
  logic        w_pop;
  logic        w_issue;
  logic        w_fault_set;

  // Unsigned subtraction makes PCs below the window wrap to huge offsets.
  assign w_off       = r_pc - RESET_VECTOR;
  assign w_pc_ok     = (w_off < TEXT_SIZE) && (r_pc[1:0] == 2'b00);
  assign w_ack       = imem_ack & r_req;
  assign w_push      = w_ack & ~r_drop;
  assign w_pop       = inst_valid & inst_ready;
  assign w_issue     = ~r_req & ~redirect_valid & ~r_fault & w_pc_ok & (r_count < DEPTH_C);
  assign w_fault_set = ~redirect_valid & ~w_pc_ok & ~r_fault & ~r_req & (r_count == '0);

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign inst_valid  = (r_count != '0) && !r_fault;
  assign inst        = inst_valid ? r_fifo_inst[r_rd_ptr] : 32'h0;
  assign inst_pc     = inst_valid ? r_fifo_pc[r_rd_ptr] : 32'h0;
  assign fault_valid = r_fault;
  assign fault_pc    = r_fault_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_VECTOR;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_drop     <= 1'b0;
      r_fault    <= 1'b0;
      r_fault_pc <= 32'h0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      // The address is latched at issue so it stays put across a redirect.
      if (w_ack) begin
        r_req <= 1'b0;
      end else if (w_issue) begin
        r_req  <= 1'b1;
        r_addr <= w_off[IMEM_AW+1:2];
      end

      if (redirect_valid) begin
        r_pc     <= redirect_pc;
        r_fault  <= 1'b0;
        r_drop   <= r_req & ~imem_ack;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_ack && r_drop) r_drop <= 1'b0;
        if (w_push) begin
          r_pc     <= r_pc + 32'd4;
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        if (w_fault_set) begin
          r_fault    <= 1'b1;
          r_fault_pc <= r_pc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !redirect_valid) begin
      r_fifo_inst[r_wr_ptr] <= imem_rdata;
      r_fifo_pc[r_wr_ptr]   <= r_pc;
    end
  end

endmodule

// File: tb/tb_mips32_fetch_unit.sv
// tb/tb_mips32_fetch_unit.sv - self-checking bench for mips32_fetch_unit
module tb_mips32_fetch_unit;

  localparam logic [31:0] RV    = 32'h00400000;
  localparam int          TEXT  = 4096;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ack = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fault_valid;
  logic [31:0] fault_pc;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mips32_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .fault_valid(fault_valid), .fault_pc(fault_pc)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h20080005 + a * 32'h0000FFFE;
  endfunction

  assign imem_rdata = rom_word(32'(imem_addr));

  function automatic bit pc_ok(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - RV;
    return (off < 32'(TEXT)) && (pc[1:0] == 2'b00);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Reference model: PC, queue of fetched words, one outstanding request.
  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  bit          m_out, m_drop, m_fault;
  logic [31:0] m_pc = RV;
  logic [31:0] m_fault_pc = 32'h0;
  logic [9:0]  m_addr = 10'h0;

  always @(posedge clk) begin : model
    bit   ack, pop, okpc, issue, fset;
    ent_t e;
    if (rst) begin
      q.delete();
      m_pc = RV; m_out = 0; m_drop = 0; m_fault = 0; m_fault_pc = 32'h0; m_addr = 10'h0;
    end else begin
      ack   = imem_ack && m_out;
      pop   = (q.size() != 0) && !m_fault && inst_ready;
      okpc  = pc_ok(m_pc);
      issue = !m_out && !redirect_valid && okpc && !m_fault && (q.size() < DEPTH);
      fset  = !redirect_valid && !okpc && !m_fault && !m_out && (q.size() == 0);
      if (redirect_valid) begin
        q.delete();
        m_drop  = m_out && !ack;
        m_out   = m_out && !ack;
        m_pc    = redirect_pc;
        m_fault = 0;
      end else begin
        if (pop) e = q.pop_front();
        if (ack) begin
          m_out = 0;
          if (m_drop) m_drop = 0;
          else begin
            q.push_back('{word: rom_word((m_pc - RV) >> 2), pc: m_pc});
            m_pc = m_pc + 32'd4;
          end
        end else if (issue) begin
          m_out  = 1;
          m_addr = 10'((m_pc - RV) >> 2);
        end
        if (fset) begin
          m_fault    = 1;
          m_fault_pc = m_pc;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_imem_req", 32'(imem_req), 32'(m_out));
      chk("cmp_inst_valid", 32'(inst_valid), 32'((q.size() != 0) && !m_fault));
      chk("cmp_fault_valid", 32'(fault_valid), 32'(m_fault));
      if (m_out) chk("cmp_imem_addr", 32'(imem_addr), 32'(m_addr));
      if ((q.size() != 0) && !m_fault) begin
        chk("cmp_inst", inst, q[0].word);
        chk("cmp_inst_pc", inst_pc, q[0].pc);
      end
      if (m_fault) chk("cmp_fault_pc", fault_pc, m_fault_pc);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'h0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'h0);
    chk({tag, "_valid"}, 32'(inst_valid), 32'h0);
    chk({tag, "_fault"}, 32'(fault_valid), 32'h0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_inst_pc"}, inst_pc, 32'h0);
    chk({tag, "_fault_pc"}, fault_pc, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    cyc(2);
    chk_reset_outputs("reset");
    chk_en = 1'b1;

    // Streaming with same-cycle acks
    rst = 1'b0; imem_ack = 1'b1; inst_ready = 1'b1;
    cyc(1);
    chk("t1_req", 32'(imem_req), 32'h1);
    chk("t1_addr0", 32'(imem_addr), 32'h0);
    cyc(1);
    chk("t1_first_valid", 32'(inst_valid), 32'h1);
    chk("t1_first_pc", inst_pc, 32'h00400000);
    chk("t1_first_inst", inst, 32'h20080005);
    cyc(2);
    chk("t1_second_pc", inst_pc, 32'h00400004);
    chk("t1_second_inst", inst, 32'h20090003);
    cyc(10);

    // Backpressure fills exactly FIFO_DEPTH entries
    rst = 1'b1; cyc(1);
    rst = 1'b0; inst_ready = 1'b0;
    cyc(10);
    chk("t2_req_low", 32'(imem_req), 32'h0);
    chk("t2_valid", 32'(inst_valid), 32'h1);
    chk("t2_head_pc", inst_pc, 32'h00400000);
    inst_ready = 1'b1;
    cyc(1);
    chk("t2_next_pc", inst_pc, 32'h00400004);
    cyc(8);

    // Redirect while a request is pending: acked word is dropped
    rst = 1'b1; cyc(1);
    rst = 1'b0; imem_ack = 1'b1; inst_ready = 1'b1;
    cyc(6);
    imem_ack = 1'b0;
    cyc(1);
    chk("t3_pending_req", 32'(imem_req), 32'h1);
    chk("t3_pending_addr", 32'(imem_addr), 32'h3);
    redirect_valid = 1'b1; redirect_pc = 32'h00400040;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(3);
    chk("t3_held_addr", 32'(imem_addr), 32'h3);
    imem_ack = 1'b1;
    cyc(1);
    chk("t3_drop_req", 32'(imem_req), 32'h0);
    chk("t3_drop_valid", 32'(inst_valid), 32'h0);
    cyc(1);
    chk("t3_new_addr", 32'(imem_addr), 32'd16);
    cyc(1);
    chk("t3_new_pc", inst_pc, 32'h00400040);
    chk("t3_new_inst", inst, 32'h2017FFE5);
    cyc(4);

    // Out-of-window and misaligned faults
    redirect_valid = 1'b1; redirect_pc = 32'h00401000;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(1);
    chk("t4_fault", 32'(fault_valid), 32'h1);
    chk("t4_fault_pc", fault_pc, 32'h00401000);
    cyc(3);
    chk("t4_fault_held", 32'(fault_valid), 32'h1);
    chk("t4_no_req", 32'(imem_req), 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h00400002;
    cyc(1);
    redirect_valid = 1'b0;
    chk("t4_fault_cleared", 32'(fault_valid), 32'h0);
    cyc(1);
    chk("t4_misalign_pc", fault_pc, 32'h00400002);
    redirect_valid = 1'b1; redirect_pc = 32'h00400008;
    cyc(1);
    redirect_valid = 1'b0;
    chk("t4_recover", 32'(fault_valid), 32'h0);
    cyc(1);
    chk("t4_recover_addr", 32'(imem_addr), 32'h2);
    cyc(4);

    // Redirect coinciding with ack and pop
    rst = 1'b1; cyc(1);
    rst = 1'b0; inst_ready = 1'b0; imem_ack = 1'b1;
    cyc(3);
    chk("t5_req", 32'(imem_req), 32'h1);
    chk("t5_valid", 32'(inst_valid), 32'h1);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h00400100;
    cyc(1);
    redirect_valid = 1'b0;
    chk("t5_flushed", 32'(inst_valid), 32'h0);
    chk("t5_req_low", 32'(imem_req), 32'h0);
    cyc(1);
    chk("t5_addr", 32'(imem_addr), 32'h40);
    cyc(1);
    chk("t5_pc", inst_pc, 32'h00400100);
    cyc(4);

    // Reset mid-transaction
    imem_ack = 1'b0;
    cyc(2);
    chk("t6_req_high", 32'(imem_req), 32'h1);
    rst = 1'b1;
    cyc(1);
    chk_reset_outputs("t6");
    rst = 1'b0; imem_ack = 1'b1;
    cyc(1);
    chk("t6_restart_req", 32'(imem_req), 32'h1);
    chk("t6_restart_addr", 32'(imem_addr), 32'h0);
    cyc(6);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
